mem_arbiter: RTL and testbench

Shares the single memory port between two requesters: port 0 (CPU controller fetch/load/store) and port 1 (program loader / debug port). Arbitrates and sequences one memory transaction at a time, waits out the memory latency, and returns a one-cycle ack with registered read data. Sits between the requesters' address/data muxes and the memory.

---
 rtl/mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory port between two requesters. Port 0 is the CPU controller
// (fetch/load/store) and port 1 is the program loader / debug port. The block
// runs one transaction at a time through IDLE -> ISSUE -> WAIT -> ACK. It waits
// out the memory latency and then returns a one-cycle ack together with
// registered read data. Every output is driven directly from a flop.
//
// Parameters
//   WORD_SIZE      data width
//   MEM_ADDR_SIZE  address width
//   MEM_LATENCY    cycles from the memory sampling the command to valid
//                  mem_rdata (legal range 1..15)
//
// Ports
//   clock, reset              rising-edge clock, asynchronous active-low reset
//   req0/we0/addr0/wdata0     port 0 request (held until ack0), write flag,
//                             address and write data
//   ack0/rdata0               port 0 completion pulse and last read data
//   req1/.../rdata1           the same set of signals for port 1
//   busy                      high while a transaction is in flight
//   mem_read/mem_write        one-cycle memory strobes
//   mem_addr/mem_wdata        memory command address and write data
//   mem_rdata                 memory read data
//
// Optional feature
//   MEM_ARB_FIXED_PRIO_EN  When this macro is defined, port 0 always wins a
//                          simultaneous request. When it is undefined,
//                          simultaneous requests alternate round-robin.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int WORD_SIZE     = 16,
  parameter int MEM_ADDR_SIZE = 6,
  parameter int MEM_LATENCY   = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req0,
  input  logic                     we0,
  input  logic [MEM_ADDR_SIZE-1:0] addr0,
  input  logic [WORD_SIZE-1:0]     wdata0,
  output logic                     ack0,
  output logic [WORD_SIZE-1:0]     rdata0,
  input  logic                     req1,
  input  logic                     we1,
  input  logic [MEM_ADDR_SIZE-1:0] addr1,
  input  logic [WORD_SIZE-1:0]     wdata1,
  output logic                     ack1,
  output logic [WORD_SIZE-1:0]     rdata1,
  output logic                     busy,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [MEM_ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]     mem_wdata,
  input  logic [WORD_SIZE-1:0]     mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY);

  state_t                   state_q, state_d;
  logic                     last_grant_q, last_grant_d;
  logic                     grant_q, grant_d;      // 1 = port 1 owns the transaction
  logic                     we_q, we_d;
  logic [3:0]               cnt_q, cnt_d;
  logic                     mem_read_q, mem_read_d;
  logic                     mem_write_q, mem_write_d;
  logic [MEM_ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0]     mem_wdata_q, mem_wdata_d;
  logic                     ack0_q, ack0_d;
  logic                     ack1_q, ack1_d;
  logic [WORD_SIZE-1:0]     rdata0_q, rdata0_d;
  logic [WORD_SIZE-1:0]     rdata1_q, rdata1_d;
  logic                     busy_q, busy_d;
  logic                     pick1;

  // Choose the winner from the requests sampled in IDLE.
`ifdef MEM_ARB_FIXED_PRIO_EN
  assign pick1 = req1 && !req0;
`else
  // When both ports request, the port that was not served last wins.
  assign pick1 = req1 && (!req0 || !last_grant_q);
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    busy_d       = busy_q;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d      = pick1;
          last_grant_d = pick1;
          we_d         = pick1 ? we1    : we0;
          mem_addr_d   = pick1 ? addr1  : addr0;
          mem_wdata_d  = pick1 ? wdata1 : wdata0;
          // The strobe is registered now, so it is visible for the whole
          // ISSUE cycle and drops again on the next edge.
          mem_read_d   = !we_d;
          mem_write_d  = we_d;
          busy_d       = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          // The memory data is valid on this edge. Only a read updates the
          // owner's data register.
          cnt_d = 4'd0;
          if (!we_q) begin
            if (grant_q) rdata1_d = mem_rdata;
            else         rdata0_d = mem_rdata;
          end
          ack0_d  = !grant_q;
          ack1_d  = grant_q;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;   // port 0 wins the first contest
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= 4'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = busy_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Two arbiters share one clock and reset: inst0 uses MEM_LATENCY=1 and inst1
// uses MEM_LATENCY=4. A latency-accurate memory model answers each read. It
// drives random junk on mem_rdata except in the one cycle where the data is
// due. The reference model works one transaction at a time: it picks the
// winner by round-robin or fixed priority, keeps a word-level memory image,
// and tracks the expected rdata of each port. It derives every expected
// strobe, ack and data value from those rules and from fixed cycle offsets
// relative to the grant edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic              clock;
  logic              reset;
  logic [1:0]        req0, we0, req1, we1;
  logic [1:0]        ack0, ack1, busy, mem_read, mem_write;
  logic [1:0][5:0]   addr0, addr1, mem_addr;
  logic [1:0][15:0]  wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [15:0] ref_mem   [2][64];
  logic [15:0] ref_rdata [2][2];
  logic        last_grant[2];
  int          last_port;

  // Memory model state
  int          pend  [2];
  logic [5:0]  paddr [2];

`ifdef MEM_ARB_FIXED_PRIO_EN
  int exp_order [4] = '{0, 0, 0, 0};
`else
  int exp_order [4] = '{0, 1, 0, 1};
`endif

  mem_arbiter #(.WORD_SIZE(16), .MEM_ADDR_SIZE(6), .MEM_LATENCY(1)) dut0 (
    .clock(clock), .reset(reset),
    .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
    .ack0(ack0[0]), .rdata0(rdata0[0]),
    .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
    .ack1(ack1[0]), .rdata1(rdata1[0]),
    .busy(busy[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_arbiter #(.WORD_SIZE(16), .MEM_ADDR_SIZE(6), .MEM_LATENCY(4)) dut1 (
    .clock(clock), .reset(reset),
    .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
    .ack0(ack0[1]), .rdata0(rdata0[1]),
    .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
    .ack1(ack1[1]), .rdata1(rdata1[1]),
    .busy(busy[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // The memory samples the command on the edge that ends the strobe cycle.
  // The read word is valid only in the cycle just before the edge that comes
  // MEM_LATENCY cycles after that sample.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      mem_rdata[i] <= 16'($urandom);
      if (mem_read[i]) begin
        if (lat(i) == 1) mem_rdata[i] <= ref_mem[i][mem_addr[i]];
        else begin
          pend[i]  <= lat(i) - 1;
          paddr[i] <= mem_addr[i];
        end
      end else if (pend[i] > 0) begin
        if (pend[i] == 1) mem_rdata[i] <= ref_mem[i][paddr[i]];
        pend[i] <= pend[i] - 1;
      end
    end
  end

  task automatic chk(input string tag, input int inst, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, inst, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input int inst);
    chk({tag, "_ctl"}, inst,
        64'({busy[inst], ack1[inst], ack0[inst], mem_read[inst], mem_write[inst]}), 64'd0);
    chk({tag, "_data"}, inst,
        64'({rdata0[inst], rdata1[inst], mem_addr[inst], mem_wdata[inst]}), 64'd0);
  endtask

  task automatic rand_port(input int inst, input int p);
    if (p == 0) begin
      we0[inst] = 1'($urandom); addr0[inst] = 6'($urandom_range(0, 7));
      wdata0[inst] = 16'($urandom);
    end else begin
      we1[inst] = 1'($urandom); addr1[inst] = 6'($urandom_range(0, 7));
      wdata1[inst] = 16'($urandom);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      last_grant[i]   = 1'b1;
      ref_rdata[i][0] = 16'h0;
      ref_rdata[i][1] = 16'h0;
    end
  endtask

  // Call this just after an edge, with the arbiter idle and the request
  // inputs already set up. The next edge is the grant edge E0. The task
  // returns #1 after edge E0+L+2, when the arbiter is back in IDLE.
  task automatic txn(input int inst, input bit drop_after_grant);
    int w;
    int L;
    logic we;
    logic [5:0] a;
    logic [15:0] d;
    L = lat(inst);
    if (req0[inst] && req1[inst]) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = last_grant[inst] ? 0 : 1;
`endif
    end else begin
      w = req1[inst] ? 1 : 0;
    end
    last_grant[inst] = (w == 1);
    we = (w == 1) ? we1[inst]    : we0[inst];
    a  = (w == 1) ? addr1[inst]  : addr0[inst];
    d  = (w == 1) ? wdata1[inst] : wdata0[inst];
    if (!we) ref_rdata[inst][w] = ref_mem[inst][a];
    else     ref_mem[inst][a]   = d;

    @(posedge clock); #1;  // E0
    chk("issue_busy",  inst, 64'(busy[inst]), 64'd1);
    chk("issue_rd",    inst, 64'(mem_read[inst]), 64'(!we));
    chk("issue_wr",    inst, 64'(mem_write[inst]), 64'(we));
    chk("issue_addr",  inst, 64'(mem_addr[inst]), 64'(a));
    chk("issue_wdata", inst, 64'(mem_wdata[inst]), 64'(d));
    chk("issue_ack",   inst, 64'({ack1[inst], ack0[inst]}), 64'd0);
    if (drop_after_grant) begin
      if (w == 0) req0[inst] = 1'b0;
      else        req1[inst] = 1'b0;
    end
    // Scramble the losing port's inputs. The arbiter must ignore them until
    // its next IDLE sample.
    rand_port(inst, 1 - w);

    for (int k = 0; k < L; k++) begin
      @(posedge clock); #1;
      chk("wait_ctl",  inst,
          64'({busy[inst], mem_read[inst], mem_write[inst], ack1[inst], ack0[inst]}),
          64'(5'b10000));
      chk("wait_addr", inst, 64'(mem_addr[inst]), 64'(a));
    end

    @(posedge clock); #1;  // ack is visible here and is sampled at E0+L+2
    chk("ack",    inst, 64'({busy[inst], ack1[inst], ack0[inst]}),
        64'((w == 1) ? 3'b110 : 3'b101));
    chk("rdata0", inst, 64'(rdata0[inst]), 64'(ref_rdata[inst][0]));
    chk("rdata1", inst, 64'(rdata1[inst]), 64'(ref_rdata[inst][1]));
    $display("[TB] inst%0d port%0d %s addr=%02h wdata=%04h rdata=%04h", inst, w,
             we ? "write" : "read ", a, d, ref_rdata[inst][w]);

    @(posedge clock); #1;
    chk("post_ack", inst,
        64'({busy[inst], ack1[inst], ack0[inst], mem_read[inst], mem_write[inst]}), 64'd0);
    last_port = w;
  endtask

  initial begin
    reset = 1'b0;
    req0 = '0; req1 = '0; we0 = '0; we1 = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 64; a++) ref_mem[i][a] = 16'($urandom);
    model_reset();

    // Hold both requests on inst0 while reset is active.
    req0[0] = 1'b1; req1[0] = 1'b1;
    rand_port(0, 0); rand_port(0, 1);
    repeat (2) @(posedge clock);
    #1;
    chk_quiet("reset0", 0);
    chk_quiet("reset1", 1);
    reset = 1'b1;

    for (int n = 0; n < 4; n++) begin
      txn(0, 1'b0);
      chk("grant_order", 0, 64'(last_port), 64'(exp_order[n]));
      rand_port(0, last_port);  // keep the request high with new fields
    end
    req0[0] = 1'b0; req1[0] = 1'b0;
    @(posedge clock); #1;
    chk("idle_busy", 0, 64'(busy[0]), 64'd0);

    // Port 0 reads address 0x05, which holds 0x1234.
    ref_mem[0][5] = 16'h1234;
    req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 6'h05;
    txn(0, 1'b0);
    chk("t1_rdata0", 0, 64'(rdata0[0]), 64'h1234);
    req0[0] = 1'b0;

    // Port 1 writes 0xBEEF to address 0x3F, then port 0 reads it back.
    req1[0] = 1'b1; we1[0] = 1'b1; addr1[0] = 6'h3F; wdata1[0] = 16'hBEEF;
    txn(0, 1'b0);
    req1[0] = 1'b0;
    req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 6'h3F;
    txn(0, 1'b0);
    chk("t2_readback", 0, 64'(rdata0[0]), 64'hBEEF);
    req0[0] = 1'b0;

    // Port 0 read with MEM_LATENCY=4.
    ref_mem[1][9] = 16'hA5C3;
    req0[1] = 1'b1; we0[1] = 1'b0; addr0[1] = 6'h09;
    txn(1, 1'b0);
    chk("t4_rdata0", 1, 64'(rdata0[1]), 64'hA5C3);
    req0[1] = 1'b0;

    // Reset asserted during WAIT aborts the transaction without an ack.
    req0[1] = 1'b1; we0[1] = 1'b0; addr0[1] = 6'h2A;
    @(posedge clock); #1;           // grant edge
    @(posedge clock); #1;           // now in WAIT
    chk("t5_in_wait", 1, 64'(busy[1]), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk_quiet("t5_async1", 1);
    chk_quiet("t5_async0", 0);
    req0[1] = 1'b0;
    model_reset();
    for (int n = 0; n < 6; n++) begin
      @(posedge clock); #1;
      chk("t5_no_ack", 1,
          64'({busy[1], ack1[1], ack0[1], mem_read[1], mem_write[1]}), 64'd0);
    end
    reset = 1'b1;
    req0[1] = 1'b1; we0[1] = 1'b0; addr0[1] = 6'h2A;
    txn(1, 1'b0);
    req0[1] = 1'b0;

    // Port 0 drops req0 one cycle after the grant and still gets one ack.
    req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 6'h11;
    txn(0, 1'b1);
    @(posedge clock); #1;
    chk("t6_single_ack", 0, 64'({busy[0], ack1[0], ack0[0]}), 64'd0);

    // Random traffic on both instances.
    for (int inst = 0; inst < 2; inst++) begin
      req0[inst] = 1'b0; req1[inst] = 1'b0;
      for (int n = 0; n < 30; n++) begin
        if (!req0[inst] && !req1[inst]) begin
          int pat;
          pat = $urandom_range(1, 3);
          req0[inst] = pat[0]; req1[inst] = pat[1];
          rand_port(inst, 0); rand_port(inst, 1);
        end
        txn(inst, ($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 1) == 1) begin
          if (last_port == 0) req0[inst] = 1'b1;
          else                req1[inst] = 1'b1;
          rand_port(inst, last_port);
        end else begin
          if (last_port == 0) req0[inst] = 1'b0;
          else                req1[inst] = 1'b0;
        end
        if (!req0[inst] && !req1[inst]) begin
          @(posedge clock); #1;
          chk("rand_idle", inst, 64'(busy[inst]), 64'd0);
        end
      end
      req0[inst] = 1'b0; req1[inst] = 1'b0;
      @(posedge clock); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
